sha256_hash_ctrl: RTL and testbench
===================================

SHA256_HASH_CTRL -- requirements
Module: sha256_hash_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, default 512, message block width; DIGEST_WIDTH, default 256, hash width; TIMEOUT, default 1024, max cycles from core_start to core_done.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 blk_valid  in  1  padded block offered by the message packer.
REQ-005 blk_data  in  DATA_WIDTH  padded 512-bit block, big-endian.
REQ-006 blk_last  in  1  block is the final block of its message.
REQ-007 blk_ready  out  1  controller can accept a block this cycle.
REQ-008 core_start  out  1  one-cycle pulse that starts SHA-256 compression.
REQ-009 core_block  out  DATA_WIDTH  block under compression.
REQ-010 core_first  out  1  core uses the H0 IV (1) or its chained state (0).
REQ-011 core_done  in  1  one-cycle pulse; compression finished.
REQ-012 core_digest  in  DIGEST_WIDTH  core intermediate/final hash, valid with core_done.
REQ-013 digest_out  out  DIGEST_WIDTH  final message digest.
REQ-014 digest_valid  out  1  one-cycle pulse; digest_out valid.
REQ-015 blk_count  out  16  blocks completed in the current message.
REQ-016 err_timeout  out  1  one-cycle pulse; core exceeded TIMEOUT.

Function
REQ-017 A one-entry block buffer (data plus last flag) SHALL exist; blk_ready = !buf_full; accept = blk_valid & blk_ready.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE -> ISSUE when buf_full; on that edge core_block, core_first and cur_last load from buffer/first_r, and the buffer empties.
REQ-020 ISSUE SHALL last exactly one cycle with core_start=1, then go to WAIT; core_start SHALL be 0 in every other state.
REQ-021 core_block and core_first SHALL hold stable from ISSUE entry until leaving WAIT.
REQ-022 WAIT with core_done: blk_count increments (wraps at 65535); if cur_last go to DONE, else clear first_r and go to IDLE.
REQ-023 DONE SHALL last one cycle: digest_out <= core_digest latched at the core_done edge, digest_valid=1, first_r <= 1, blk_count <= 0 on exit, then IDLE.
REQ-024 Accepts SHALL be allowed in every state while the buffer is empty, including on the same edge as core_done.
REQ-025 core_done outside WAIT SHALL be ignored, with no state, count or output change.
REQ-026 A watchdog counter SHALL clear on ISSUE and count in WAIT; if it reaches TIMEOUT without core_done, pulse err_timeout, set first_r=1, clear blk_count, empty buffer, go to IDLE.
REQ-027 Latency: an accept in IDLE SHALL produce core_start two cycles later (buffer edge, then ISSUE); core_done of a last block SHALL produce digest_valid in the next cycle.

Reset
REQ-028 Reset SHALL set state=IDLE, buf_full=0, first_r=1, core_start=0, core_block=0, core_first=1, digest_out=0, digest_valid=0, blk_count=0, err_timeout=0, watchdog=0.
REQ-029 Reset asserted mid-message SHALL discard buffered and in-flight blocks; the next block after release SHALL use core_first=1.

Structure
REQ-030 The shared sha256_pkg SHALL hold the FSM state encodings, DATA_WIDTH, DIGEST_WIDTH and the default TIMEOUT.
REQ-031 The block buffer SHALL be the sub-module sha256_blk_buf (1-deep valid/ready register slice); the FSM and watchdog SHALL stay in the top module.

Verification
REQ-032 Single block "abc" (0x61626380...0018, last=1): core_start once with core_first=1; core_done with digest ba7816bf...f20015ad -> digest_valid 1 cycle later, digest_out equal, blk_count returns to 0.
REQ-033 Two-block message: second core_start has core_first=0; digest_valid only after the second core_done; blk_count=2 before clear.
REQ-034 blk_valid held high during WAIT: one block accepted, then blk_ready=0 until the next ISSUE; no block is lost or duplicated.
REQ-035 TIMEOUT=16 with core_done never asserted: err_timeout pulses 16 cycles into WAIT, FSM returns to IDLE, and the next block uses core_first=1.
REQ-036 rst_n low during WAIT of block 1 of 2, then a new 1-block message: core_first=1, correct digest, and no spurious digest_valid.
REQ-037 core_done pulsed in IDLE: no output change.

Source files
------------

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_pkg
// Description : Shared constants for the SHA-256 hash controller: default
//               widths, default watchdog limit and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    // Default block / digest widths and core watchdog limit
    localparam int SHA256_DATA_WIDTH   = 512;
    localparam int SHA256_DIGEST_WIDTH = 256;
    localparam int SHA256_TIMEOUT      = 1024;

    // Completed-block counter type (wraps naturally at 65535)
    typedef logic [15:0] blk_cnt_t;

    // Controller FSM state encodings
    localparam int         STATE_W    = 2;
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_blk_buf.sv
`default_nettype none
// ============================================================================
// Module      : sha256_blk_buf
// Description : One-deep valid/ready register slice holding a padded block
//               and its last-block flag until the controller issues it.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_blk_buf
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = SHA256_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  w_accept;

    assign in_ready = !r_full;
    assign w_accept = in_valid && !r_full;

    // Occupancy: a flush (watchdog recovery) empties the slot unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    // Payload capture on every accepted handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_last <= in_last;
        end
    end

    assign full     = r_full;
    assign out_data = r_data;
    assign out_last = r_last;

endmodule : sha256_blk_buf
`default_nettype wire

// File: rtl/sha256_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_hash_ctrl
// Description : Sequences padded message blocks into a SHA-256 compression
//               core, chains intermediate state across blocks, publishes the
//               final digest and recovers from a hung core via a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_hash_ctrl
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH   = SHA256_DATA_WIDTH,
    parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
    parameter int TIMEOUT      = SHA256_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    blk_valid,
    input  logic [DATA_WIDTH-1:0]   blk_data,
    input  logic                    blk_last,
    output logic                    blk_ready,
    output logic                    core_start,
    output logic [DATA_WIDTH-1:0]   core_block,
    output logic                    core_first,
    input  logic                    core_done,
    input  logic [DIGEST_WIDTH-1:0] core_digest,
    output logic [DIGEST_WIDTH-1:0] digest_out,
    output logic                    digest_valid,
    output logic [15:0]             blk_count,
    output logic                    err_timeout
);

    // Watchdog sized to hold TIMEOUT; expiry is flagged on the WAIT cycle
    // whose count would reach TIMEOUT.
    localparam int                c_wd_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT - 1);

    logic [STATE_W-1:0]      r_state;
    logic                    r_first;
    logic                    r_cur_last;
    logic [DATA_WIDTH-1:0]   r_core_block;
    logic                    r_core_first;
    logic [DIGEST_WIDTH-1:0] r_digest_out;
    logic                    r_digest_valid;
    blk_cnt_t                r_blk_count;
    logic                    r_err_timeout;
    logic [c_wd_w-1:0]       r_wd;

    logic                    w_buf_full;
    logic [DATA_WIDTH-1:0]   w_buf_data;
    logic                    w_buf_last;
    logic                    w_pop;
    logic                    w_wd_expire;

    // Buffer is drained on the IDLE->ISSUE edge and flushed on a timeout
    assign w_pop       = (r_state == c_st_idle) && w_buf_full;
    assign w_wd_expire = (r_state == c_st_wait) && !core_done && (r_wd == c_wd_limit);

    sha256_blk_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_blk_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (blk_valid),
        .in_data  (blk_data),
        .in_last  (blk_last),
        .in_ready (blk_ready),
        .pop      (w_pop),
        .flush    (w_wd_expire),
        .full     (w_buf_full),
        .out_data (w_buf_data),
        .out_last (w_buf_last)
    );

    // Main sequencer: issue, wait for the core, chain or finish the message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_first        <= 1'b1;
            r_cur_last     <= 1'b0;
            r_core_block   <= '0;
            r_core_first   <= 1'b1;
            r_digest_out   <= '0;
            r_digest_valid <= 1'b0;
            r_blk_count    <= '0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            r_err_timeout  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_buf_full) begin
                        r_core_block <= w_buf_data;
                        r_core_first <= r_first;
                        r_cur_last   <= w_buf_last;
                        r_state      <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (core_done) begin
                        r_blk_count <= r_blk_count + 16'd1;
                        if (r_cur_last) begin
                            r_digest_out   <= core_digest;
                            r_digest_valid <= 1'b1;
                            r_state        <= c_st_done;
                        end else begin
                            r_first <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end else if (w_wd_expire) begin
                        r_err_timeout <= 1'b1;
                        r_first       <= 1'b1;
                        r_blk_count   <= '0;
                        r_state       <= c_st_idle;
                    end
                end
                c_st_done: begin
                    r_first     <= 1'b1;
                    r_blk_count <= '0;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Watchdog: cleared while issuing, advances every WAIT cycle without done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (r_state == c_st_issue) begin
            r_wd <= '0;
        end else if ((r_state == c_st_wait) && !core_done && !w_wd_expire) begin
            r_wd <= r_wd + c_wd_w'(1);
        end
    end

    assign core_start   = (r_state == c_st_issue);
    assign core_block   = r_core_block;
    assign core_first   = r_core_first;
    assign digest_out   = r_digest_out;
    assign digest_valid = r_digest_valid;
    assign blk_count    = r_blk_count;
    assign err_timeout  = r_err_timeout;

endmodule : sha256_hash_ctrl
`default_nettype wire

// File: tb/tb_sha256_hash_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_hash_ctrl
// Description : Directed + randomized bench for sha256_hash_ctrl. The bench
//               plays the compression core with a toy chaining function and
//               predicts each message digest by folding its block list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_hash_ctrl;

    localparam int DW = 512;
    localparam int HW = 256;
    localparam int TO = 16;

    localparam logic [HW-1:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [HW-1:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          blk_valid = 1'b0;
    logic [DW-1:0] blk_data = '0;
    logic          blk_last = 1'b0;
    logic          blk_ready;
    logic          core_start;
    logic [DW-1:0] core_block;
    logic          core_first;
    logic          core_done = 1'b0;
    logic [HW-1:0] core_digest = '0;
    logic [HW-1:0] digest_out;
    logic          digest_valid;
    logic [15:0]   blk_count;
    logic          err_timeout;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int dv_seen = 0;
    int dv_exp = 0;
    logic [HW-1:0] core_chain = '0;
    logic [HW-1:0] last_exp = '0;

    always #5 clk = ~clk;

    sha256_hash_ctrl #(
        .DATA_WIDTH   (DW),
        .DIGEST_WIDTH (HW),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .core_start   (core_start),
        .core_block   (core_block),
        .core_first   (core_first),
        .core_done    (core_done),
        .core_digest  (core_digest),
        .digest_out   (digest_out),
        .digest_valid (digest_valid),
        .blk_count    (blk_count),
        .err_timeout  (err_timeout)
    );

    // Event counters sampled on the active edge
    always @(posedge clk) begin
        if (core_start === 1'b1)   start_cnt++;
        if (digest_valid === 1'b1) dv_seen++;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Toy chaining function standing in for SHA-256 compression
    function automatic logic [HW-1:0] fh(input logic [HW-1:0] c, input logic [DW-1:0] b);
        return {c[HW-2:0], c[HW-1]} ^ b[DW-1:HW] ^ b[HW-1:0] ^ 256'h5a;
    endfunction

    function automatic logic [DW-1:0] rblk();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Offer one block and hold it until the handshake edge has passed
    task automatic send_block(input logic [DW-1:0] d, input logic l);
        int n = 0;
        blk_data  = d;
        blk_last  = l;
        blk_valid = 1'b1;
        while (blk_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("accept_ready", blk_ready, 1'b1);
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (core_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("start_seen", core_start, 1'b1);
    endtask

    // Core response: done pulse after d cycles of WAIT
    task automatic do_done(input int d, input logic [HW-1:0] dig);
        repeat (d) @(negedge clk);
        core_digest = dig;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
        core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_msg(input int nb);
        logic [DW-1:0] blks[$];
        logic [HW-1:0] exp_h;
        logic [HW-1:0] dig;
        exp_h = IV;
        for (int i = 0; i < nb; i++) begin
            blks.push_back(rblk());
            exp_h = fh(exp_h, blks[i]);
        end
        for (int i = 0; i < nb; i++) begin
            send_block(blks[i], (i == nb - 1));
            wait_start();
            chk1("core_first", core_first, (i == 0));
            chkw("core_block", core_block, blks[i]);
            dig = fh(core_first ? IV : core_chain, core_block);
            core_chain = dig;
            do_done($urandom_range(1, 8), dig);
            if (i == nb - 1) begin
                dv_exp++;
                last_exp = exp_h;
                chk1("digest_valid", digest_valid, 1'b1);
                chkw("digest_out", DW'(digest_out), DW'(exp_h));
                chkw("blk_count_full", DW'(blk_count), DW'(nb));
                @(negedge clk);
                chk1("digest_valid_drop", digest_valid, 1'b0);
                chkw("blk_count_clear", DW'(blk_count), DW'(0));
            end else begin
                chk1("no_early_digest", digest_valid, 1'b0);
                chkw("blk_count_mid", DW'(blk_count), DW'(i + 1));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] a, b, c, abc;
        logic [HW-1:0] dig;
        int sc0;
        int n;
        bit stray;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_ready", blk_ready, 1'b1);
        chk1("rst_start", core_start, 1'b0);
        chk1("rst_first", core_first, 1'b1);
        chkw("rst_block", core_block, '0);
        chkw("rst_digest", DW'(digest_out), '0);
        chk1("rst_dvalid", digest_valid, 1'b0);
        chkw("rst_count", DW'(blk_count), '0);
        chk1("rst_tmo", err_timeout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single "abc" block with real digest and latency checks
        abc = {32'h61626380, 416'h0, 64'h18};
        sc0 = start_cnt;
        send_block(abc, 1'b1);
        chk1("lat_buffer_edge", core_start, 1'b0);
        @(negedge clk);
        chk1("lat_issue", core_start, 1'b1);
        chk1("abc_first", core_first, 1'b1);
        chkw("abc_block", core_block, abc);
        do_done(3, ABC_DIG);
        dv_exp++;
        last_exp = ABC_DIG;
        chk1("abc_dvalid", digest_valid, 1'b1);
        chkw("abc_digest", DW'(digest_out), DW'(ABC_DIG));
        chkw("abc_count", DW'(blk_count), DW'(1));
        @(negedge clk);
        chk1("abc_dvalid_drop", digest_valid, 1'b0);
        chkw("abc_count_clear", DW'(blk_count), '0);
        chkw("abc_one_start", DW'(start_cnt - sc0), DW'(1));

        // Randomized messages; the first is a two-block message
        run_msg(2);
        for (int m = 0; m < 4; m++) run_msg($urandom_range(1, 3));

        // blk_valid held through WAIT: A,B form one message, C another
        a = rblk(); b = rblk(); c = rblk();
        send_block(a, 1'b0);
        wait_start();
        chk1("hold_a_first", core_first, 1'b1);
        chkw("hold_a_block", core_block, a);
        blk_data = b; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        chk1("hold_b_taken", blk_ready, 1'b0);
        blk_data = c; blk_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("hold_ready_low", blk_ready, 1'b0);
        end
        do_done(1, fh(IV, a));
        chk1("hold_ready_idle", blk_ready, 1'b0);
        wait_start();
        chk1("hold_b_first", core_first, 1'b0);
        chkw("hold_b_block", core_block, b);
        chk1("hold_ready_issue", blk_ready, 1'b1);
        @(negedge clk);
        blk_valid = 1'b0;
        chk1("hold_c_taken", blk_ready, 1'b0);
        do_done(2, fh(fh(IV, a), b));
        dv_exp++;
        chk1("hold_b_dvalid", digest_valid, 1'b1);
        chkw("hold_b_digest", DW'(digest_out), DW'(fh(fh(IV, a), b)));
        chkw("hold_b_count", DW'(blk_count), DW'(2));
        @(negedge clk);
        wait_start();
        chk1("hold_c_first", core_first, 1'b1);
        chkw("hold_c_block", core_block, c);
        do_done(2, fh(IV, c));
        dv_exp++;
        last_exp = fh(IV, c);
        chkw("hold_c_digest", DW'(digest_out), DW'(fh(IV, c)));
        @(negedge clk);

        // Watchdog: block 1 completes, block 2 never finishes
        a = rblk(); b = rblk();
        send_block(a, 1'b0);
        wait_start();
        do_done(2, fh(IV, a));
        chkw("tmo_count_pre", DW'(blk_count), DW'(1));
        send_block(b, 1'b0);
        wait_start();
        chk1("tmo_b_first", core_first, 1'b0);
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chkw("tmo_cycles", DW'(n), DW'(17));
        chk1("tmo_pulse", err_timeout, 1'b1);
        chkw("tmo_count_clear", DW'(blk_count), '0);
        chk1("tmo_ready", blk_ready, 1'b1);
        @(negedge clk);
        chk1("tmo_pulse_drop", err_timeout, 1'b0);
        chk1("tmo_no_start", core_start, 1'b0);
        run_msg(1);

        // Reset during WAIT of block 1 of 2, with block 2 already buffered
        a = rblk(); b = rblk();
        send_block(a, 1'b0);
        wait_start();
        send_block(b, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("mrst_ready", blk_ready, 1'b1);
        chk1("mrst_first", core_first, 1'b1);
        chkw("mrst_count", DW'(blk_count), '0);
        chkw("mrst_digest", DW'(digest_out), '0);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (core_start === 1'b1) stray = 1'b1;
        end
        chk1("mrst_buf_discarded", stray, 1'b0);
        run_msg(1);

        // core_done while idle must be ignored
        core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chkw("idle_done_digest", DW'(digest_out), DW'(last_exp));
        chk1("idle_done_dvalid", digest_valid, 1'b0);
        chk1("idle_done_start", core_start, 1'b0);
        chkw("idle_done_count", DW'(blk_count), '0);
        @(negedge clk);
        chk1("idle_done_start2", core_start, 1'b0);
        run_msg(2);

        repeat (3) @(negedge clk);
        chkw("digest_valid_pulses", DW'(dv_seen), DW'(dv_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sha256_hash_ctrl
`default_nettype wire
